// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs multi-cycle unit.
// Optional statistics counters are enabled by defining WB_ARB_STATS_EN.
module wb_port_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int RWIDTH       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CWIDTH       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_valid_i,
  output logic              pipe_ready_o,
  input  logic [RWIDTH-1:0] pipe_rd_i,
  input  logic [DWIDTH-1:0] pipe_data_i,
  input  logic              mcu_valid_i,
  output logic              mcu_ready_o,
  input  logic [RWIDTH-1:0] mcu_rd_i,
  input  logic [DWIDTH-1:0] mcu_data_i,
  output logic              rf_we_o,
  output logic [RWIDTH-1:0] rf_rd_o,
  output logic [DWIDTH-1:0] rf_data_o,
  output logic              starve_stall_o
`ifdef WB_ARB_STATS_EN
  ,
  output logic [CWIDTH-1:0] pipe_grants_o,
  output logic [CWIDTH-1:0] mcu_grants_o,
  output logic [CWIDTH-1:0] stall_cycles_o
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LAST = SW'(STARVE_LIMIT - 1);

  typedef enum logic {ARB, FORCE} state_t;

  state_t            r_state;
  logic [SW-1:0]     r_cnt;
  logic              r_we;
  logic [RWIDTH-1:0] r_rd;
  logic [DWIDTH-1:0] r_data;

  logic w_coll;
  logic w_pipe_xfer;
  logic w_mcu_xfer;
  logic w_mcu_blocked;

  assign w_coll = pipe_valid_i && mcu_valid_i
                  && (pipe_rd_i == mcu_rd_i);

  always_comb begin
    pipe_ready_o = 1'b0;
    mcu_ready_o  = 1'b0;
    unique case (r_state)
      ARB: begin
        pipe_ready_o = 1'b1;
        mcu_ready_o  = mcu_valid_i && (!pipe_valid_i || w_coll);
      end
      FORCE: begin
        mcu_ready_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_pipe_xfer   = pipe_valid_i && pipe_ready_o;
  assign w_mcu_xfer    = mcu_valid_i && mcu_ready_o;
  assign w_mcu_blocked = mcu_valid_i && !mcu_ready_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ARB;
      r_cnt   <= '0;
    end else if (r_state == FORCE) begin
      r_state <= ARB;
      r_cnt   <= '0;
    end else if (w_mcu_blocked) begin
      if (r_cnt == LAST) begin
        r_state <= FORCE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // A collision retires the MCU result but only the pipeline value is written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_pipe_xfer) begin
        if (pipe_rd_i != '0) begin
          r_we   <= 1'b1;
          r_rd   <= pipe_rd_i;
          r_data <= pipe_data_i;
        end
      end else if (w_mcu_xfer && mcu_rd_i != '0) begin
        r_we   <= 1'b1;
        r_rd   <= mcu_rd_i;
        r_data <= mcu_data_i;
      end
    end
  end

  assign rf_we_o        = r_we;
  assign rf_rd_o        = r_rd;
  assign rf_data_o      = r_data;
  assign starve_stall_o = (r_state == FORCE);

`ifdef WB_ARB_STATS_EN
  logic [CWIDTH-1:0] r_pg;
  logic [CWIDTH-1:0] r_mg;
  logic [CWIDTH-1:0] r_sc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pg <= '0;
      r_mg <= '0;
      r_sc <= '0;
    end else begin
      if (w_pipe_xfer && r_pg != '1) r_pg <= r_pg + 1'b1;
      if (w_mcu_xfer && r_mg != '1) r_mg <= r_mg + 1'b1;
      if (r_state == FORCE && r_sc != '1) r_sc <= r_sc + 1'b1;
    end
  end

  assign pipe_grants_o  = r_pg;
  assign mcu_grants_o   = r_mg;
  assign stall_cycles_o = r_sc;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every register-file write.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid_i;
  logic        pipe_ready_o;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        mcu_valid_i;
  logic        mcu_ready_o;
  logic [4:0]  mcu_rd_i;
  logic [31:0] mcu_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic        starve_stall_o;
`ifdef WB_ARB_STATS_EN
  logic [15:0] pipe_grants_o;
  logic [15:0] mcu_grants_o;
  logic [15:0] stall_cycles_o;
`endif

  wb_port_arbiter #(
    .DWIDTH(32), .RWIDTH(5), .STARVE_LIMIT(4), .CWIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pipe_valid_i(pipe_valid_i),
    .pipe_ready_o(pipe_ready_o),
    .pipe_rd_i(pipe_rd_i),
    .pipe_data_i(pipe_data_i),
    .mcu_valid_i(mcu_valid_i),
    .mcu_ready_o(mcu_ready_o),
    .mcu_rd_i(mcu_rd_i),
    .mcu_data_i(mcu_data_i),
    .rf_we_o(rf_we_o),
    .rf_rd_o(rf_rd_o),
    .rf_data_o(rf_data_o),
    .starve_stall_o(starve_stall_o)
`ifdef WB_ARB_STATS_EN
    ,
    .pipe_grants_o(pipe_grants_o),
    .mcu_grants_o(mcu_grants_o),
    .stall_cycles_o(stall_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  ep    = 0;
  int  em    = 0;
  int  es    = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rf_we_o) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL spurious_write rd=%0d data=%h", rf_rd_o, rf_data_o);
      end else begin
        wr_t e;
        e = q.pop_front();
        if (rf_rd_o !== e.rd || rf_data_o !== e.d) begin
          bad++;
          $display("FAIL rf_write act=%0d/%h exp=%0d/%h",
                   rf_rd_o, rf_data_o, e.rd, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic drive(input logic pv, input logic [4:0] prd,
                       input logic [31:0] pd, input logic mv,
                       input logic [4:0] mrd, input logic [31:0] md);
    pipe_valid_i = pv;
    pipe_rd_i    = prd;
    pipe_data_i  = pd;
    mcu_valid_i  = mv;
    mcu_rd_i     = mrd;
    mcu_data_i   = md;
  endtask

  task automatic idle();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic contend(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1, 3, base + i, 1, 7, 32'h77);
      #1;
      chk("cont_pready", pipe_ready_o, 1);
      chk("cont_mready", mcu_ready_o, 0);
      chk("cont_stall", starve_stall_o, 0);
      q.push_back({5'd3, base + i});
      ep++;
    end
  endtask

  task automatic force_cycle(input logic [31:0] d);
    @(negedge clk);
    drive(1, 3, d, 1, 7, 32'h77);
    #1;
    chk("force_stall", starve_stall_o, 1);
    chk("force_pready", pipe_ready_o, 0);
    chk("force_mready", mcu_ready_o, 1);
    q.push_back({5'd7, 32'h77});
    em++;
    es++;
    @(negedge clk);
    drive(1, 3, d, 0, 0, 0);
    #1;
    chk("post_force_stall", starve_stall_o, 0);
    chk("post_force_pready", pipe_ready_o, 1);
    q.push_back({5'd3, d});
    ep++;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_we", rf_we_o, 0);
    chk("rst_rd", rf_rd_o, 0);
    chk("rst_data", rf_data_o, 0);
    chk("rst_stall", starve_stall_o, 0);
    reset = 1'b0;

    // pipeline only
    @(negedge clk);
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    #1;
    chk("pipe_pready", pipe_ready_o, 1);
    chk("pipe_mready", mcu_ready_o, 0);
    q.push_back({5'd5, 32'hDEADBEEF});
    ep++;
    idle();

    // same-rd collision: pipeline value wins, MCU retired
    @(negedge clk);
    drive(1, 9, 32'h11, 1, 9, 32'h22);
    #1;
    chk("coll_pready", pipe_ready_o, 1);
    chk("coll_mready", mcu_ready_o, 1);
    q.push_back({5'd9, 32'h11});
    ep++;
    em++;
    idle();

    // MCU alone
    @(negedge clk);
    drive(0, 0, 0, 1, 12, 32'hABC);
    #1;
    chk("mcu_mready", mcu_ready_o, 1);
    q.push_back({5'd12, 32'hABC});
    em++;
    idle();

    // starvation -> forced slot
    contend(4, 32'h100);
    force_cycle(32'h104);
    idle();

    // x0 write is accepted but suppressed
    @(negedge clk);
    drive(1, 0, 32'hFFFF, 0, 0, 0);
    #1;
    chk("x0_pready", pipe_ready_o, 1);
    ep++;
    @(negedge clk);
    chk("x0_we", rf_we_o, 0);
    drive(0, 0, 0, 0, 0, 0);

    // a transfer clears the starvation count
    contend(2, 32'h180);
    @(negedge clk);
    drive(0, 0, 0, 1, 7, 32'h77);
    #1;
    chk("clr_mready", mcu_ready_o, 1);
    q.push_back({5'd7, 32'h77});
    em++;
    contend(4, 32'h1A0);
    force_cycle(32'h1A4);
    idle();

    // reset in the middle of a forced cycle
    contend(4, 32'h200);
    @(negedge clk);
    drive(1, 3, 32'h204, 1, 7, 32'h77);
    #1;
    chk("mid_force_stall", starve_stall_o, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_we", rf_we_o, 0);
    chk("arst_rd", rf_rd_o, 0);
    chk("arst_data", rf_data_o, 0);
    chk("arst_stall", starve_stall_o, 0);
    drive(0, 0, 0, 0, 0, 0);
    ep = 0;
    em = 0;
    es = 0;
    @(negedge clk);
    reset = 1'b0;

    // counter restarts from zero after reset
    contend(4, 32'h300);
    force_cycle(32'h304);
    repeat (3) idle();

    chk("queue_empty", q.size(), 0);
`ifdef WB_ARB_STATS_EN
    chk("stat_pipe", pipe_grants_o, ep);
    chk("stat_mcu", mcu_grants_o, em);
    chk("stat_stall", stall_cycles_o, es);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between two sources. One is the in-order pipeline writeback stream, carrying the writeback-stage result. The other is a multi-cycle unit (MCU: mul/div/long-latency load) that completes out of band. Fixed priority goes to the pipeline; a starvation counter forces an MCU slot and stalls the pipeline for one cycle. The write port is registered, and the block sits between writeback and the register file.

Parameters:
DWIDTH, 32, write data width
RWIDTH, 5, register index width
STARVE_LIMIT, 4, consecutive cycles MCU may wait before a forced grant (>=1)
CWIDTH, 16, width of statistics counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
pipe_valid_i  in  1  pipeline writeback request
pipe_ready_o  out  1  pipeline write accepted this cycle
pipe_rd_i  in  RWIDTH  pipeline destination register
pipe_data_i  in  DWIDTH  pipeline writeback data
mcu_valid_i  in  1  MCU result request; held with rd/data until accepted
mcu_ready_o  out  1  MCU result accepted this cycle
mcu_rd_i  in  RWIDTH  MCU destination register
mcu_data_i  in  DWIDTH  MCU result data
rf_we_o  out  1  register-file write enable (registered)
rf_rd_o  out  RWIDTH  register-file write index (registered)
rf_data_o  out  DWIDTH  register-file write data (registered)
starve_stall_o  out  1  high during a forced MCU cycle; decode/fetch must freeze

Behaviour:
- Handshake: a transfer occurs when valid && ready in the same cycle.
- Ready signals are combinational from state and the current valid/rd inputs, with no dependency on the ready outputs.
- The valid inputs must not drop before their transfer completes.
- States: ARB (default) and FORCE.
- ARB:
  - pipe_ready_o = 1.
  - mcu_ready_o = mcu_valid_i && (!pipe_valid_i || collision).
  - collision = pipe_valid_i && mcu_valid_i && pipe_rd_i == mcu_rd_i.
- FORCE:
  - pipe_ready_o = 0, mcu_ready_o = 1, starve_stall_o = 1.
  - Returns to ARB next cycle.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - Increments each ARB cycle with mcu_valid_i && !mcu_ready_o.
  - Clears on any MCU transfer, or when mcu_valid_i = 0.
  - When the counter equals STARVE_LIMIT-1 and the MCU is again blocked, the next state is FORCE and the counter clears.
- Collision (same rd, same cycle):
  - The pipeline value is written, since it is the younger instruction.
  - The MCU result is retired (mcu_ready_o = 1) but discarded.
- Write port latency is 1 cycle. On the edge after a transfer, rf_we_o/rf_rd_o/rf_data_o take the winning source's values.
- With no transfer, or a discarded collision, rf_we_o = 0 and rf_rd_o/rf_data_o hold their values.
- x0: a transfer with rd = 0 is accepted normally, but rf_we_o stays 0.
- Only one source ever drives the write port per cycle.
- Reset (async, any cycle):
  - State goes to ARB and the counter to 0.
  - rf_we_o = 0, rf_rd_o = 0, rf_data_o = 0, starve_stall_o = 0.
  - A write in flight is lost; the MCU must re-present its result after reset.
- If mcu_valid_i falls while in FORCE (protocol violation), no write occurs and the block returns to ARB.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined:
  - Adds outputs pipe_grants_o, mcu_grants_o, stall_cycles_o, each CWIDTH wide.
  - The grant counters count transfers, including x0 and discarded collisions.
  - stall_cycles_o counts FORCE cycles.
  - All three saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Pipe-only: pipe_valid=1, rd=5, data=0xDEADBEEF, mcu idle -> pipe_ready=1; next cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF.
- Contention: both valid, pipe rd=3, mcu rd=7, pipe valid every cycle, STARVE_LIMIT=4 -> mcu_ready=0 for 4 cycles. Cycle 5 is FORCE: starve_stall=1, pipe_ready=0, mcu_ready=1. Next edge: rf_rd=7.
- Collision: both valid, rd=9, pipe data=0x11, mcu data=0x22 -> both ready=1; next cycle rf_rd=9, rf_data=0x11; no write of 0x22 ever appears.
- x0: pipe rd=0, data=0xFFFF -> pipe_ready=1; rf_we stays 0.
- Reset mid-FORCE: assert reset asynchronously while starve_stall=1 -> all outputs 0 immediately; after release the block is in ARB and the counter starts from 0.
- WB_ARB_STATS_EN: 10 pipe transfers, 2 MCU transfers, 1 forced -> pipe_grants=10, mcu_grants=2, stall_cycles=1.
